// File: rtl/rca_stage_pkg.sv
// Shared types for the ripple-carry adder stage: operand width and the captured result word.
package rca_stage_pkg;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic              crout;
      logic [DATA_W-1:0] sum;
   } rca_result_t;
endpackage

// File: rtl/rca_sync_fifo.sv
// First-word fall-through FIFO with occupancy count; a push into a full FIFO without a pop is dropped.
module rca_sync_fifo #(
   parameter  int WIDTH  = 65,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int FILL_W = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              pop,
   output logic [WIDTH-1:0]  rdata,
   output logic              valid,
   output logic              full,
   output logic              wr_en,
   output logic [FILL_W-1:0] fill
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             rd_en;

   assign valid = (fill != '0);
   assign full  = (fill == FILL_W'(DEPTH));
   assign rd_en = pop && valid;
   // A simultaneous pop frees the slot, so a push at full is still accepted.
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      fill <= fill + 1'b1;
         else if (!wr_en && rd_en) fill <= fill - 1'b1;
      end
   end

   overflow_chk : assert property (@(posedge clock) disable iff (reset) !(push && full && !pop));
endmodule

// File: rtl/rca_result_buffer.sv
// Tracks operands issued to the fixed-latency adder, captures their results into a FIFO,
// and grants credit to the operand source so no result can ever be lost.
module rca_result_buffer
   import rca_stage_pkg::*;
#(
   parameter  int LATENCY = 2,
   parameter  int DEPTH   = 4,
   parameter  int CNT_W   = 32,
   localparam int FILL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] res_sum,
   input  logic              res_crout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_sum,
   output logic              out_crout,
   output logic [FILL_W-1:0] fill,
   output logic [CNT_W-1:0]  carry_count,
   output logic              proto_err
);
   localparam int INF_W = $clog2(LATENCY + 1);
   localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);

   logic [LATENCY-1:0] tag;
   logic [INF_W-1:0]   inflight;
   logic [OCC_W-1:0]   occ;
   logic               issue;
   logic               push;
   logic               pop;
   logic               wr_en;
   logic               fifo_full;
   rca_result_t        wdata;
   rca_result_t        rdata;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + INF_W'(tag[i]);
   end

   // Pops are not credited back in the same cycle, keeping out_ready off the op_ready path.
   assign occ      = OCC_W'(fill) + OCC_W'(inflight);
   assign op_ready = !reset && (occ < OCC_W'(DEPTH));
   assign issue    = op_valid && op_ready;
   assign push     = tag[LATENCY-1];
   assign pop      = out_valid && out_ready;
   assign wdata    = '{crout: res_crout, sum: res_sum};

   rca_sync_fifo #(
      .WIDTH ($bits(rca_result_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .valid (out_valid),
      .full  (fifo_full),
      .wr_en (wr_en),
      .fill  (fill)
   );

   assign out_sum   = rdata.sum;
   assign out_crout = rdata.crout;

   always_ff @(posedge clock) begin
      if (reset) begin
         tag         <= '0;
         carry_count <= '0;
         proto_err   <= 1'b0;
      end else begin
         tag <= (tag << 1) | LATENCY'(issue);
         if (wr_en && res_crout && (carry_count != {CNT_W{1'b1}}))
            carry_count <= carry_count + 1'b1;
         if (op_valid && !op_ready)
            proto_err <= 1'b1;
      end
   end
endmodule
